lif_step_scheduler: RTL
=======================

# lif_step_scheduler

Time-multiplexed controller that shares one 8-bit leaky integrate-and-fire update datapath among N_NEURONS virtual neurons. It holds a per-neuron membrane-state bank and a per-neuron pending-current buffer. On each step request it sweeps the neurons one per cycle, then presents the resulting spike vector on a valid/ready output. It sits between the host-side stimulus interface and the downstream spike consumer, and replaces one physical neuron per channel.

## Interface
- N_NEURONS, 4: number of virtual neurons; at least 2.
- WIDTH, 8: membrane state, current and threshold width.
- DEFAULT_THRESHOLD, 32: threshold value loaded at reset.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; **asynchronous, active-high**.
- in_valid  in  1  current-write request.
- in_ready  out  1  high only in IDLE.
- in_idx  in  $clog2(N_NEURONS)  target neuron of the current write.
- in_current  in  WIDTH  current value; overwrites that neuron's pending current.
- thr_we  in  1  threshold write; honoured only in IDLE.
- thr_data  in  WIDTH  new global threshold.
- step  in  1  request one update sweep; sampled only in IDLE.
- busy  out  1  high in UPDATE and DONE.
- spk_valid  out  1  spike vector available.
- spk_ready  in  1  consumer accepts the spike vector.
- spk  out  N_NEURONS  bit i is neuron i's spike for the completed sweep.
- rd_idx  in  $clog2(N_NEURONS)  debug read address.
- rd_state  out  WIDTH  combinational read of state[rd_idx].

## Operation
- **FSM states:** IDLE, UPDATE, DONE.
- **IDLE**
  - If in_valid is high: cur[in_idx] <= in_current.
  - If thr_we is high: threshold <= thr_data.
  - If step is high: ptr <= 0 and go to UPDATE.
  - Same-edge write and step: the written current and threshold are used by the sweep that starts.
- **UPDATE**, neuron ptr, one per edge:
  - s = state[ptr].
  - sp = (s >= threshold), unsigned compare.
  - state[ptr] <= cur[ptr] + (sp ? 0 : s >> 1), truncated to WIDTH. Wrap-around is mod 2^WIDTH; no saturation.
  - spk[ptr] <= sp.
  - cur[ptr] <= 0. Pending current is consumed once.
  - ptr increments. After ptr = N_NEURONS-1 is processed, go to DONE and set spk_valid <= 1.
- **DONE**
  - spk and spk_valid are held stable until the edge where spk_valid && spk_ready.
  - On that edge: spk_valid <= 0 and go to IDLE. spk keeps its last value.
- **Ignored inputs**
  - in_valid, thr_we and step are ignored in UPDATE and DONE. No queuing; in_ready is low there.
- **Reset** (asserted at any time, including mid-sweep):
  - Immediately sets: all state = 0, all cur = 0, threshold = DEFAULT_THRESHOLD, FSM = IDLE, ptr = 0, spk = 0, spk_valid = 0.
  - Resulting outputs: busy = 0, in_ready = 1.
  - A partial sweep is discarded.

## Timing
- The step-sampling edge is E0. Neuron i is updated at edge E(i+1).
- spk_valid rises after edge E(N_NEURONS); busy rises after E0.
- Minimum step-to-step period is N_NEURONS + 2 cycles, with spk_ready tied high.
- A spike reflects the pre-update state, i.e. the previous sweep's result (one-sweep latency from current to spike).
- in_ready and busy are registered-state decodes with no combinational path from inputs.
- rd_state is combinational from rd_idx; it shows a neuron's new value on the cycle after its update edge.

## Test plan
1. **Reset values.** Assert rst mid-UPDATE -> spk_valid=0, busy=0, in_ready=1, rd_state=0 for all idx. After release, a step with no currents -> spk=0000.
2. **Spike path** (N=4, thr 32).
   - Write cur0=40, then step -> spk=0000, state0=40.
   - Step again with no currents -> spk=0001, state0=0.
3. **Leak accumulation.**
   - cur1=20, step -> state1=20.
   - cur1=20, step -> state1=30, spk bit1=0.
4. **Wrap-around.**
   - thr_we 255, cur2=200, step -> state2=200.
   - cur2=200, step -> state2=44 (300 mod 256), spk=0000.
5. **Handshake and ignore.**
   - Hold spk_ready=0 for 5 cycles after spk_valid -> spk stable, busy=1.
   - Pulse step and in_valid during DONE -> no effect.
   - spk_ready=1 -> IDLE next edge.
6. **Same-edge write and step.** in_valid (idx3, 50) and step on the same edge -> state3=50 after the sweep, and cur3 reads back as consumed (the next sweep adds 0).

Source files
------------

// File: rtl/lif_step_scheduler_if.sv
// lif_step_scheduler_if
// Groups the host-side stimulus port, the spike output handshake and the
// debug read port of the LIF step scheduler.
//   master : host / consumer side (drives requests, reads status and spikes)
//   slave  : scheduler side
// Signals:
//   in_valid/in_ready/in_idx/in_current : pending-current write
//   thr_we/thr_data                     : global threshold write
//   step/busy                           : sweep request and activity flag
//   spk_valid/spk_ready/spk             : spike vector handshake
//   rd_idx/rd_state                     : combinational membrane-state read
interface lif_step_scheduler_if #(
  parameter int N_NEURONS = 4,
  parameter int WIDTH     = 8
);
  localparam int IDX_W = $clog2(N_NEURONS);

  logic                 in_valid;
  logic                 in_ready;
  logic [IDX_W-1:0]     in_idx;
  logic [WIDTH-1:0]     in_current;
  logic                 thr_we;
  logic [WIDTH-1:0]     thr_data;
  logic                 step;
  logic                 busy;
  logic                 spk_valid;
  logic                 spk_ready;
  logic [N_NEURONS-1:0] spk;
  logic [IDX_W-1:0]     rd_idx;
  logic [WIDTH-1:0]     rd_state;

  modport master (
    output in_valid, in_idx, in_current, thr_we, thr_data, step, spk_ready, rd_idx,
    input  in_ready, busy, spk_valid, spk, rd_state
  );

  modport slave (
    input  in_valid, in_idx, in_current, thr_we, thr_data, step, spk_ready, rd_idx,
    output in_ready, busy, spk_valid, spk, rd_state
  );
endinterface

// File: rtl/lif_step_scheduler.sv
// lif_step_scheduler
// Shares one leaky integrate-and-fire update datapath among N_NEURONS virtual
// neurons. A step request sweeps the neurons one per clock, then the spike
// vector is offered on a valid/ready handshake.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : lif_step_scheduler_if slave modport (current/threshold writes,
//          step/busy, spike handshake, debug state read)
module lif_step_scheduler #(
  parameter int N_NEURONS         = 4,
  parameter int WIDTH             = 8,
  parameter int DEFAULT_THRESHOLD = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  lif_step_scheduler_if.slave   bus
);
  localparam int IDX_W = $clog2(N_NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

  typedef enum logic [1:0] {
    IDLE,
    UPDATE,
    DONE
  } fsm_t;

  fsm_t                 fsm_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [WIDTH-1:0]     state_q [N_NEURONS];
  logic [WIDTH-1:0]     cur_q   [N_NEURONS];
  logic [WIDTH-1:0]     thr_q;
  logic [N_NEURONS-1:0] spk_q;
  logic                 spkValid_q;

  logic [WIDTH-1:0]     curState;
  logic                 spikeNow;
  logic [WIDTH-1:0]     state_d;

  // Shared update datapath for the neuron under the sweep pointer. A spiking
  // neuron drops its leaked term entirely (reset-to-current); otherwise the
  // state leaks by half. The sum wraps modulo 2^WIDTH by design.
  always_comb begin
    curState = state_q[ptr_q];
    spikeNow = (curState >= thr_q);
    state_d  = cur_q[ptr_q] + (spikeNow ? '0 : (curState >> 1));
  end

  // Controller: IDLE accepts writes and step requests, UPDATE walks the
  // neurons, DONE holds the spike vector until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q      <= IDLE;
      ptr_q      <= '0;
      thr_q      <= WIDTH'(DEFAULT_THRESHOLD);
      spk_q      <= '0;
      spkValid_q <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        state_q[i] <= '0;
        cur_q[i]   <= '0;
      end
    end else begin
      case (fsm_q)
        IDLE: begin
          if (bus.in_valid) begin
            cur_q[bus.in_idx] <= bus.in_current;
          end
          if (bus.thr_we) begin
            thr_q <= bus.thr_data;
          end
          if (bus.step) begin
            ptr_q <= '0;
            fsm_q <= UPDATE;
          end
        end
        UPDATE: begin
          state_q[ptr_q] <= state_d;
          spk_q[ptr_q]   <= spikeNow;
          // Pending current is consumed exactly once per sweep.
          cur_q[ptr_q]   <= '0;
          if (ptr_q == LAST_IDX) begin
            ptr_q      <= '0;
            fsm_q      <= DONE;
            spkValid_q <= 1'b1;
          end else begin
            ptr_q <= ptr_q + 1'b1;
          end
        end
        DONE: begin
          if (spkValid_q && bus.spk_ready) begin
            spkValid_q <= 1'b0;
            fsm_q      <= IDLE;
          end
        end
        default: begin
          fsm_q <= IDLE;
        end
      endcase
    end
  end

  // Status flags decode only registered state, so there is no input-to-output
  // combinational path through the handshake.
  assign bus.in_ready  = (fsm_q == IDLE);
  assign bus.busy      = (fsm_q != IDLE);
  assign bus.spk_valid = spkValid_q;
  assign bus.spk       = spk_q;
  assign bus.rd_state  = state_q[bus.rd_idx];

endmodule
